// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states and default widths/constants
// used by the fetch stage and its pipeline registers.
package pipeline_pkg;

  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INSTR_W  = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP  = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register (valid/pc/instr) with flush > stall > load
// priority; with none of them asserted a bubble is inserted.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               stall,
  input  logic               load,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr
);

  // On flush only valid is cleared; pc/instr keep their old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (stall) begin
      valid <= valid;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem request handshake and
// feeds the IF/ID register, surviving wait states, stalls and redirects.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEF_PC_STEP)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_hazard_detected,
  input  logic               i_branch_taken,
  input  logic [ADDR_W-1:0]  i_branch_target,
  fetch_stage_if.master      imem,
  output logic               o_if_id_valid,
  output logic [ADDR_W-1:0]  o_if_id_pc,
  output logic [INSTR_W-1:0] o_if_id_instr
);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  hold_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  pc_next_seq;

  logic               if_id_load;
  logic [ADDR_W-1:0]  if_id_load_pc;
  logic [INSTR_W-1:0] if_id_load_instr;

  assign pc_next_seq    = pc + PC_STEP;
  assign imem.imem_req  = (state == FETCH) || (state == DROP);
  assign imem.imem_addr = pc;

  // HOLD always offers the buffered instruction; a still-asserted hazard
  // keeps it out because stall outranks load inside the register.
  always_comb begin
    if_id_load       = 1'b0;
    if_id_load_pc    = pc;
    if_id_load_instr = imem.imem_rdata;
    case (state)
      FETCH: if_id_load = imem.imem_ack;
      HOLD: begin
        if_id_load       = 1'b1;
        if_id_load_pc    = hold_pc;
        if_id_load_instr = hold_instr;
      end
      default: if_id_load = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      redirect_pc <= '0;
      hold_pc     <= '0;
      hold_instr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (i_branch_taken) pc <= i_branch_target;
        end
        FETCH: begin
          if (imem.imem_ack) begin
            if (i_branch_taken) begin
              pc <= i_branch_target;
            end else if (i_hazard_detected) begin
              hold_instr <= imem.imem_rdata;
              hold_pc    <= pc;
              pc         <= pc_next_seq;
              state      <= HOLD;
            end else begin
              pc <= pc_next_seq;
            end
          end else if (i_branch_taken) begin
            redirect_pc <= i_branch_target;
            state       <= DROP;
          end
        end
        // The stale request must complete before the redirect is issued.
        DROP: begin
          if (i_branch_taken) redirect_pc <= i_branch_target;
          if (imem.imem_ack) begin
            pc    <= i_branch_taken ? i_branch_target : redirect_pc;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (i_branch_taken) begin
            hold_instr <= '0;
            hold_pc    <= '0;
            pc         <= i_branch_target;
            state      <= FETCH;
          end else if (!i_hazard_detected) begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .flush      (i_branch_taken),
    .stall      (i_hazard_detected),
    .load       (if_id_load),
    .load_pc    (if_id_load_pc),
    .load_instr (if_id_load_instr),
    .valid      (o_if_id_valid),
    .pc         (o_if_id_pc),
    .instr      (o_if_id_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, wait states, hazard hold,
// redirect during an outstanding request, async reset and PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard;
  logic        branch;
  logic [31:0] target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  int          checks = 0;
  int          errors = 0;

  fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem_bus ();

  fetch_stage #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0),
    .PC_STEP  (32'h4)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_hazard_detected (hazard),
    .i_branch_taken    (branch),
    .i_branch_target   (target),
    .imem              (imem_bus),
    .o_if_id_valid     (if_id_valid),
    .o_if_id_pc        (if_id_pc),
    .o_if_id_instr     (if_id_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] code(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ addr;
  endfunction

  task automatic apply_stimulus(input logic ack, input logic [31:0] rdata,
                                input logic haz, input logic br,
                                input logic [31:0] tgt);
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = rdata;
    hazard              = haz;
    branch              = br;
    target              = tgt;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic expect_fetch(input string tag, input logic req,
                              input logic [31:0] addr, input logic valid);
    check_output({tag, "_req"}, {31'd0, imem_bus.imem_req}, {31'd0, req});
    if (req) check_output({tag, "_addr"}, imem_bus.imem_addr, addr);
    check_output({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr);
    check_output({tag, "_ifpc"}, if_id_pc, pc);
    check_output({tag, "_ifinstr"}, if_id_instr, instr);
  endtask

  initial begin
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_fetch("reset", 1'b0, 32'h0, 1'b0);
    check_output("reset_addr", imem_bus.imem_addr, 32'h0);
    expect_ifid("reset", 32'h0, 32'h0);
    rst_n = 1'b1;

    // Zero-wait streaming
    @(negedge clk);
    expect_fetch("first_req", 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b1, code(32'h0), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("stream4", 1'b1, 32'h4, 1'b1);
    expect_ifid("stream0", 32'h0, code(32'h0));
    apply_stimulus(1'b1, code(32'h4), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("stream8", 1'b1, 32'h8, 1'b1);
    expect_ifid("stream4", 32'h4, code(32'h4));
    apply_stimulus(1'b1, code(32'h8), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("streamc", 1'b1, 32'hC, 1'b1);
    expect_ifid("stream8", 32'h8, code(32'h8));

    // Hazard for two cycles while 0xC is acked
    apply_stimulus(1'b1, code(32'hC), 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("hazard1", 1'b0, 32'h10, 1'b1);
    expect_ifid("hazard1", 32'h8, code(32'h8));
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("hazard2", 1'b0, 32'h10, 1'b1);
    expect_ifid("hazard2", 32'h8, code(32'h8));
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("release", 1'b1, 32'h10, 1'b1);
    expect_ifid("release", 32'hC, code(32'hC));

    // 0x10 acked on its third request cycle
    @(negedge clk);
    expect_fetch("wait1", 1'b1, 32'h10, 1'b0);
    @(negedge clk);
    expect_fetch("wait2", 1'b1, 32'h10, 1'b0);
    apply_stimulus(1'b1, code(32'h10), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("after_ack", 1'b1, 32'h14, 1'b1);
    expect_ifid("after_ack", 32'h10, code(32'h10));
    apply_stimulus(1'b1, code(32'h14), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("seq18", 1'b1, 32'h18, 1'b1);
    expect_ifid("seq14", 32'h14, code(32'h14));
    apply_stimulus(1'b1, code(32'h18), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("seq1c", 1'b1, 32'h1C, 1'b1);
    apply_stimulus(1'b1, code(32'h1C), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("seq20", 1'b1, 32'h20, 1'b1);
    expect_ifid("seq1c", 32'h1C, code(32'h1C));

    // Branch to 0x100 in the second wait cycle of the 0x20 fetch
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("br_wait", 1'b1, 32'h20, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    @(negedge clk);
    expect_fetch("drop1", 1'b1, 32'h20, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("drop2", 1'b1, 32'h20, 1'b0);
    apply_stimulus(1'b1, code(32'h20), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("redirect", 1'b1, 32'h100, 1'b0);
    apply_stimulus(1'b1, code(32'h100), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("tgt_fetch", 1'b1, 32'h104, 1'b1);
    expect_ifid("tgt_fetch", 32'h100, code(32'h100));

    // Branch and hazard together: branch wins
    apply_stimulus(1'b1, code(32'h104), 1'b1, 1'b1, 32'h40);
    @(negedge clk);
    expect_fetch("br_haz", 1'b1, 32'h40, 1'b0);
    apply_stimulus(1'b1, code(32'h40), 1'b0, 1'b1, 32'h18);
    @(negedge clk);
    expect_fetch("br_ack", 1'b1, 32'h18, 1'b0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("wait18", 1'b1, 32'h18, 1'b0);

    // Asynchronous reset in the middle of the 0x18 wait
    #2 rst_n = 1'b0;
    #1;
    expect_fetch("async_rst", 1'b0, 32'h0, 1'b0);
    check_output("async_rst_addr", imem_bus.imem_addr, 32'h0);
    expect_ifid("async_rst", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_fetch("restart", 1'b1, 32'h0, 1'b0);
    apply_stimulus(1'b1, code(32'h0), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("restart_next", 1'b1, 32'h4, 1'b1);
    expect_ifid("restart", 32'h0, code(32'h0));

    // PC wraps past the top of the address space
    apply_stimulus(1'b1, code(32'h4), 1'b0, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    expect_fetch("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0);
    apply_stimulus(1'b1, code(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    expect_fetch("wrap", 1'b1, 32'h0, 1'b1);
    expect_ifid("wrap", 32'hFFFF_FFFC, code(32'hFFFF_FFFC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
